fpu_issue: RTL
==============

# fpu_issue

Command initiator for the `fpu` block: accepts FPU commands from the core pipeline, buffers them in a small in-order FIFO, and drives the FPU `ready`/`valid` request handshake one command at a time. It captures each result (`out_data`, `cond`) and returns it to the core with the destination tag. It sits between the core's FP decode stage and the `fpu` instance. It is the hardware counterpart of the stimulus sequence the FPU bench drives.

## Interface
- `DEPTH`, 4: command FIFO entries; power of two, ≥2.
- `TIMEOUT`, 1024: watchdog limit in cycles; used only with `FPU_ISSUE_TIMEOUT_EN`.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rstn`  in  1  reset; asynchronous assertion, active-low.
- `cmd_valid`  in  1  core offers a command.
- `cmd_ready`  out  1  FIFO can accept; transfer on `cmd_valid && cmd_ready` at a rising edge.
- `cmd_op`  in  6  operation code (`FPU_OP*` from `fpu_params.h`), passed through undecoded.
- `cmd_x1`, `cmd_x2`, `cmd_y`  in  5 each  source and destination register indices.
- `cmd_data`  in  32  immediate for `FPU_OPSET`.
- `fpu_operation`  out  6, `fpu_x1`/`fpu_x2`/`fpu_y`  out  5, `fpu_in_data`  out  32  fields to `fpu`.
- `fpu_ready`  out  1  request to `fpu`.
- `fpu_valid`  in  1  completion from `fpu`.
- `fpu_out_data`  in  32, `fpu_cond`  in  1  result from `fpu`.
- `res_valid`  out  1  one-cycle result pulse.
- `res_data`  out  32, `res_cond`  out  1, `res_y`  out  5  captured result and destination tag.
- `busy`  out  1  FIFO non-empty or a command in flight.
- `timeout`  out  1  sticky watchdog flag; tied 0 without the macro.

## Operation
- The FIFO `count` ranges 0..DEPTH. `cmd_ready = (count != DEPTH)`, combinational from registered state, with no bypass.
- Pointers wrap modulo DEPTH.
- The FSM has two states, IDLE and WAIT, plus ERR when the macro is enabled.
- IDLE: if `count != 0`, pop the head, load the `fpu_*` fields, set `fpu_ready` to 1, and go to WAIT. A push and pop in the same edge are both allowed; `count` is then unchanged.
- WAIT: `fpu_ready` stays 1 and all fields are held stable. When `fpu_valid` is sampled 1:
  - capture `fpu_out_data`, `fpu_cond`, and the issued `y`;
  - set `fpu_ready` to 0;
  - pulse `res_valid` on the next cycle;
  - return to IDLE.
- `fpu_valid` sampled while in IDLE is ignored and produces no `res_valid`.
- When idle, the `fpu_*` fields hold their last issued values. `res_data`, `res_cond`, and `res_y` hold until the next capture.
- Commands are issued and their results returned in strict acceptance order. At most one command is in flight.
- `busy = (count != 0) || (state != IDLE)`.
- Reset (any time, including mid-WAIT):
  - FIFO emptied; state IDLE;
  - all outputs 0 (`cmd_ready` 1 once `rstn` is high);
  - any in-flight command is dropped with no `res_valid`.

## Timing
- A command accepted at edge N with the FIFO empty and the FSM idle: `fpu_ready` is 1 after edge N+1.
- `fpu_valid` sampled at edge V: `fpu_ready` is 0 and `res_valid` is 1 after edge V; `res_valid` is 0 after V+1.
- A queued next command raises `fpu_ready` after edge V+1. `fpu_ready` is therefore low for exactly one cycle between back-to-back commands.
- When full, `cmd_ready` is 0 from the edge that made `count == DEPTH`. It returns to 1 after the edge that pops.

## Configuration
- `FPU_ISSUE_TIMEOUT_EN` defined:
  - a counter runs while in WAIT, cleared on entry to WAIT;
  - if it reaches `TIMEOUT` without `fpu_valid`, the block drops `fpu_ready`, sets `timeout` to 1, and enters ERR;
  - ERR holds `cmd_ready=0` and issues nothing until reset; `busy` stays 1.
- Not defined: WAIT waits indefinitely, there is no counter, and `timeout` is constant 0.

## Structure
- Package `fpu_issue_pkg`:
  - state enum (`S_IDLE`, `S_WAIT`, `S_ERR`);
  - `fpu_cmd_t` struct: `op[5:0]`, `x1`, `x2`, `y[4:0]`, `data[31:0]`;
  - default `DEPTH` and `TIMEOUT` constants.
- Sub-module `fpu_issue_fifo`: parameterized synchronous FIFO of `fpu_cmd_t` with push, pop, count, full, and empty. The FSM and result capture stay in `fpu_issue`.

## Test plan
- Single SET: push `op=FPU_OPSET`, `data=32'h3f800000`, `y=1`. Expect `fpu_ready=1` with `fpu_in_data=3f800000`. After `fpu_valid`, expect `res_valid` for one cycle, `res_y=1`, and `fpu_ready` low.
- Back-to-back: push SET 0→r0, SET 3f800000→r1, FADD r0,r1→r2 on consecutive cycles. Expect three issues in order, one low `fpu_ready` cycle between each, and `res_y` sequence 0, 1, 2. With model `fpu_out_data=3f800000`, the third `res_data` is 3f800000.
- Full FIFO: hold `fpu_valid=0` and push DEPTH+1 commands. Expect one in flight, `cmd_ready=0` once `count=4`, and no command lost. Pulsing `fpu_valid` restores `cmd_ready=1` on the next cycle.
- Stall: delay `fpu_valid` 20 cycles. Expect all `fpu_*` fields constant throughout. A spurious `fpu_valid` in IDLE produces no `res_valid`.
- Reset mid-WAIT: assert `rstn=0` with 2 queued commands. Expect immediate `fpu_ready=0` and `busy=0`, and no `res_valid` after release.
- With `FPU_ISSUE_TIMEOUT_EN` and `TIMEOUT=16`: never assert `fpu_valid`. Expect `timeout=1` and `fpu_ready=0` after 16 cycles in WAIT, and `cmd_ready=0` until reset.

Source files
------------

// File: rtl/fpu_issue_pkg.sv
// fpu_issue shared types: FSM states, command bundle, default sizes.
// The S_ERR state is only reachable with FPU_ISSUE_TIMEOUT_EN defined.
package fpu_issue_pkg;

  localparam int DEF_DEPTH   = 4;
  localparam int DEF_TIMEOUT = 1024;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ERR  = 2'd2
  } state_t;

  typedef struct packed {
    logic [5:0]  op;
    logic [4:0]  x1;
    logic [4:0]  x2;
    logic [4:0]  y;
    logic [31:0] data;
  } fpu_cmd_t;

endpackage

// File: rtl/fpu_issue_fifo.sv
// In-order command FIFO for fpu_issue; DEPTH must be a power of two.
// Head entry is presented combinationally on dout while not empty.
module fpu_issue_fifo
  import fpu_issue_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH
) (
  input  logic                   clk,
  input  logic                   rstn,
  input  logic                   push,
  input  fpu_cmd_t               din,
  input  logic                   pop,
  output fpu_cmd_t               dout,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);

  fpu_cmd_t        mem [DEPTH];
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic            do_push;
  logic            do_pop;

  assign full    = (count == (AW+1)'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty;
  assign dout    = mem[rd_ptr];

  // Storage array; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  // Pointers wrap by natural overflow; count tracks occupancy.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count <= count + (AW+1)'(1);
        2'b01:   count <= count - (AW+1)'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/fpu_issue.sv
// FPU command initiator: queues core commands, issues one at a time.
// Optional watchdog enabled by defining FPU_ISSUE_TIMEOUT_EN.
module fpu_issue
  import fpu_issue_pkg::*;
#(
  parameter int DEPTH   = DEF_DEPTH,
  parameter int TIMEOUT = DEF_TIMEOUT
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [5:0]  cmd_op,
  input  logic [4:0]  cmd_x1,
  input  logic [4:0]  cmd_x2,
  input  logic [4:0]  cmd_y,
  input  logic [31:0] cmd_data,
  output logic [5:0]  fpu_operation,
  output logic [4:0]  fpu_x1,
  output logic [4:0]  fpu_x2,
  output logic [4:0]  fpu_y,
  output logic [31:0] fpu_in_data,
  output logic        fpu_ready,
  input  logic        fpu_valid,
  input  logic [31:0] fpu_out_data,
  input  logic        fpu_cond,
  output logic        res_valid,
  output logic [31:0] res_data,
  output logic        res_cond,
  output logic [4:0]  res_y,
  output logic        busy,
  output logic        timeout
);

  state_t                 state;
  state_t                 state_nxt;
  fpu_cmd_t               cmd_in;
  fpu_cmd_t               head;
  logic                   push;
  logic                   pop;
  logic                   capture;
  logic                   full;
  logic                   empty;
  logic                   to_hit;
  logic [$clog2(DEPTH):0] count;

  assign cmd_in = '{
    op:   cmd_op,
    x1:   cmd_x1,
    x2:   cmd_x2,
    y:    cmd_y,
    data: cmd_data
  };

  // rstn gates ready so every output reads 0 while held in reset.
  assign cmd_ready = rstn && !full && (state != S_ERR);
  assign push      = cmd_valid && cmd_ready;
  assign busy      = (count != '0) || (state != S_IDLE);

  fpu_issue_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk   (clk),
    .rstn  (rstn),
    .push  (push),
    .din   (cmd_in),
    .pop   (pop),
    .dout  (head),
    .count (count),
    .full  (full),
    .empty (empty)
  );

`ifdef FPU_ISSUE_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT + 1);

  logic [TW-1:0] wd_cnt;

  assign to_hit = (wd_cnt == TW'(TIMEOUT - 1));

  // Watchdog: restarts on each issue, trips after TIMEOUT silent cycles.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wd_cnt  <= '0;
      timeout <= 1'b0;
    end else begin
      if (pop) begin
        wd_cnt <= '0;
      end else if (state == S_WAIT && !to_hit) begin
        wd_cnt <= wd_cnt + TW'(1);
      end
      if (state == S_WAIT && !fpu_valid && to_hit) timeout <= 1'b1;
    end
  end
`else
  assign to_hit  = 1'b0;
  assign timeout = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next state plus the pop/capture strobes.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    capture   = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (!empty) begin
          pop       = 1'b1;
          state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (fpu_valid) begin
          capture   = 1'b1;
          state_nxt = S_IDLE;
        end else if (to_hit) begin
          state_nxt = S_ERR;
        end
      end
      default: state_nxt = state;
    endcase
  end

  // Issue fields, request line and result capture registers.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      fpu_operation <= '0;
      fpu_x1        <= '0;
      fpu_x2        <= '0;
      fpu_y         <= '0;
      fpu_in_data   <= '0;
      fpu_ready     <= 1'b0;
      res_valid     <= 1'b0;
      res_data      <= '0;
      res_cond      <= 1'b0;
      res_y         <= '0;
    end else begin
      fpu_ready <= (state_nxt == S_WAIT);
      res_valid <= capture;
      if (pop) begin
        fpu_operation <= head.op;
        fpu_x1        <= head.x1;
        fpu_x2        <= head.x2;
        fpu_y         <= head.y;
        fpu_in_data   <= head.data;
      end
      if (capture) begin
        res_data <= fpu_out_data;
        res_cond <= fpu_cond;
        res_y    <= fpu_y;
      end
    end
  end

endmodule
